// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
// Frame sequencing states plus sizing helpers used by the top and its bit timer.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 217;  // 25 MHz / 115200 baud
  localparam int DATA_WIDTH           = 8;
  localparam int BIT_IDX_WIDTH        = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } tx_state_e;

  // Counter width able to hold clks_per_bit-1; never narrower than one bit.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: wraps at CLKS_PER_BIT-1 and flags that cycle.
// Held at zero while cleared so every frame starts on a fresh bit boundary.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Terminal
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] clk_count;

  // NOTE: state in always_ff uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      clk_count <= '0;
    end else if (i_Clear) begin
      clk_count <= '0;
    end else if (i_Enable) begin
      if (clk_count == LAST_COUNT) begin
        clk_count <= '0;
      end else begin
        clk_count <= clk_count + CNT_W'(1);
      end
    end
  end

  assign o_Terminal = i_Enable && (clk_count == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit,
// then a one-cycle done pulse. All outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_L,
  input  logic                  i_TX_DV,
  input  logic [DATA_WIDTH-1:0] i_TX_Byte,
  output logic                  o_TX_Active,
  output logic                  o_TX_Serial,
  output logic                  o_TX_Done
);

  localparam logic [BIT_IDX_WIDTH-1:0] LAST_BIT = BIT_IDX_WIDTH'(DATA_WIDTH - 1);

  tx_state_e                state;
  logic [BIT_IDX_WIDTH-1:0] bit_idx;
  logic [DATA_WIDTH-1:0]    tx_data;
  logic                     bit_done;
  logic                     timer_clear;
  logic                     timer_run;

  // The timer only runs while a bit is on the wire; it wraps on its own at
  // every bit boundary, so no explicit clear is needed between bits.
  assign timer_clear = (state == IDLE);
  assign timer_run   = (state == START) || (state == DATA) || (state == STOP);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_Clock   (i_Clock),
    .i_Rst_L   (i_Rst_L),
    .i_Clear   (timer_clear),
    .i_Enable  (timer_run),
    .o_Terminal(bit_done)
  );

  // The line level for the next bit is registered on the same edge that
  // changes state, so o_TX_Serial never passes through combinational logic.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      bit_idx     <= '0;
      tx_data     <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b0;
          o_TX_Done   <= 1'b0;
          bit_idx     <= '0;
          if (i_TX_DV) begin
            tx_data     <= i_TX_Byte;
            o_TX_Active <= 1'b1;
            o_TX_Serial <= 1'b0;
            state       <= START;
          end
        end

        START: begin
          if (bit_done) begin
            bit_idx     <= '0;
            o_TX_Serial <= tx_data[0];
            state       <= DATA;
          end
        end

        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_BIT) begin
              o_TX_Serial <= 1'b1;
              state       <= STOP;
            end else begin
              bit_idx     <= bit_idx + BIT_IDX_WIDTH'(1);
              o_TX_Serial <= tx_data[bit_idx + BIT_IDX_WIDTH'(1)];
            end
          end
        end

        STOP: begin
          if (bit_done) begin
            o_TX_Done   <= 1'b1;
            o_TX_Active <= 1'b0;
            state       <= CLEANUP;
          end
        end

        CLEANUP: begin
          o_TX_Done   <= 1'b0;
          o_TX_Serial <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          o_TX_Serial <= 1'b1;
          o_TX_Active <= 1'b0;
          o_TX_Done   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a slow (217) and a minimum-divider (2) instance, an acceptance
// model feeding per-lane scoreboards, and line monitors that check each frame.
module tb_uart_tx;

  typedef struct packed {
    logic [7:0]  b;
    logic [31:0] acc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       dv      [2];
  logic [7:0] tx_byte [2];
  logic       act     [2];
  logic       ser     [2];
  logic       done    [2];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   next_free [2];
  int   frames    [2];
  exp_t q0 [$];
  exp_t q1 [$];

  uart_tx #(.CLKS_PER_BIT(217)) u_dut_slow (
    .i_Clock    (clk),
    .i_Rst_L    (rst_n),
    .i_TX_DV    (dv[0]),
    .i_TX_Byte  (tx_byte[0]),
    .o_TX_Active(act[0]),
    .o_TX_Serial(ser[0]),
    .o_TX_Done  (done[0])
  );

  uart_tx #(.CLKS_PER_BIT(2)) u_dut_fast (
    .i_Clock    (clk),
    .i_Rst_L    (rst_n),
    .i_TX_DV    (dv[1]),
    .i_TX_Byte  (tx_byte[1]),
    .o_TX_Active(act[1]),
    .o_TX_Serial(ser[1]),
    .o_TX_Done  (done[1])
  );

  initial begin
    clk = 1'b1;
    forever #20 clk = ~clk;
  end

  function automatic int cpb(input int l);
    return (l == 0) ? 217 : 2;
  endfunction

  function automatic void push_exp(input int l, input exp_t e);
    if (l == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic int q_len(input int l);
    return (l == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t pop_exp(input int l);
    if (l == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void flush_exp(input int l);
    if (l == 0) q0.delete();
    else        q1.delete();
  endfunction

  task automatic check(input string name, input int l, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s lane%0d cycle %0d: got %0h want %0h", name, l, cyc, got, want);
    end
  endtask

  // Acceptance model: a lane is free once 10 bit periods plus done and
  // return-to-idle cycles have passed since its last accepted byte.
  initial begin
    next_free[0] = 0;
    next_free[1] = 0;
    forever begin
      @(posedge clk);
      for (int l = 0; l < 2; l++) begin
        if (!rst_n) begin
          next_free[l] = 0;
          flush_exp(l);
        end else if (dv[l] && cyc >= next_free[l]) begin
          push_exp(l, '{b: tx_byte[l], acc: cyc});
          next_free[l] = cyc + 10 * cpb(l) + 2;
        end
      end
      cyc++;
    end
  end

  task automatic monitor(input int l);
    exp_t e;
    int   n;
    int   errs;
    int   fi;
    logic eb;
    bit   live;
    n = 10 * cpb(l);
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (ser[l] === 1'b1) begin
        if (act[l] !== 1'b0 || done[l] !== 1'b0)
          check("idle_outputs", l, {act[l], done[l]}, 2'b00);
        continue;
      end
      if (q_len(l) == 0) begin
        check("unexpected_frame", l, 1, 0);
        repeat (n + 1) @(negedge clk);
        continue;
      end
      e = pop_exp(l);
      check("start_time", l, cyc, e.acc + 1);
      errs = 0;
      live = 1'b1;
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(negedge clk);
        if (!rst_n) begin
          live = 1'b0;
          break;
        end
        fi = k / cpb(l);
        eb = (fi == 0) ? 1'b0 : (fi == 9) ? 1'b1 : e.b[fi-1];
        if (ser[l] !== eb || act[l] !== 1'b1) errs++;
      end
      if (!live) continue;
      check($sformatf("frame_bits_%02h", e.b), l, errs, 0);
      @(negedge clk);
      if (!rst_n) continue;
      check("done_pulse", l, {done[l], act[l], ser[l]}, 3'b101);
      @(negedge clk);
      if (!rst_n) continue;
      check("done_clear", l, {done[l], act[l]}, 2'b00);
      frames[l]++;
    end
  endtask

  initial begin
    frames[0] = 0;
    frames[1] = 0;
    fork
      monitor(0);
      monitor(1);
    join
  end

  task automatic wait_done(input int l, input int budget);
    int i;
    i = 0;
    while (done[l] !== 1'b1 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", l, done[l], 1'b1);
  endtask

  task automatic lane0_directed();
    int hits;
    @(negedge clk);
    tx_byte[0] = 8'h37;
    dv[0]      = 1'b1;
    repeat (3) @(negedge clk);
    dv[0]      = 1'b0;
    tx_byte[0] = 8'($urandom);
    // A byte offered mid-frame must be ignored entirely.
    repeat (1000) @(negedge clk);
    tx_byte[0] = 8'hA5;
    dv[0]      = 1'b1;
    @(negedge clk);
    dv[0]      = 1'b0;
    tx_byte[0] = 8'($urandom);
    wait_done(0, 3000);
    // Back-to-back: DV raised in the done cycle and held into idle.
    tx_byte[0] = 8'h00;
    dv[0]      = 1'b1;
    repeat (2) @(negedge clk);
    dv[0] = 1'b0;
    wait_done(0, 3000);
    tx_byte[0] = 8'hFF;
    dv[0]      = 1'b1;
    repeat (2) @(negedge clk);
    dv[0] = 1'b0;
    wait_done(0, 3000);
    // Abort a frame with reset during data bit 3.
    repeat (3) @(negedge clk);
    tx_byte[0] = 8'hC3;
    dv[0]      = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (968) @(negedge clk);
    @(posedge clk);
    #7 rst_n = 1'b0;
    #1;
    check("abort_line", 0, {ser[0], act[0]}, 2'b10);
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (done[0] !== 1'b0) hits++;
    end
    rst_n = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (done[0] !== 1'b0) hits++;
    end
    check("abort_no_done", 0, hits, 0);
    tx_byte[0] = 8'h55;
    dv[0]      = 1'b1;
    @(negedge clk);
    dv[0] = 1'b0;
    wait_done(0, 3000);
    repeat (5) @(negedge clk);
  endtask

  task automatic lane1_random();
    @(negedge clk);
    tx_byte[1] = 8'h81;
    dv[1]      = 1'b1;
    @(negedge clk);
    dv[1] = 1'b0;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 6000; i++) begin
      dv[1]      = ($urandom_range(0, 5) == 0);
      tx_byte[1] = 8'($urandom);
      @(negedge clk);
    end
    dv[1] = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    dv[0]      = 1'b0;
    dv[1]      = 1'b0;
    tx_byte[0] = 8'h00;
    tx_byte[1] = 8'h00;
    #50;
    for (int l = 0; l < 2; l++) check("reset_hold", l, {ser[l], act[l], done[l]}, 3'b100);
    #50 rst_n = 1'b1;
    @(posedge clk);
    #5;
    for (int l = 0; l < 2; l++) check("reset_release", l, {ser[l], act[l], done[l]}, 3'b100);
    fork
      lane0_directed();
      lane1_random();
    join
    repeat (50) @(negedge clk);
    check("queue_drained", 0, q0.size(), 0);
    check("queue_drained", 1, q1.size(), 0);
    check("frame_count", 0, frames[0], 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for a UART link, 8N1 framing: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Accepts one byte per `i_TX_DV` strobe and shifts it out at `CLKS_PER_BIT` clocks per bit.
- Reports busy status, and a one-cycle done pulse at end of frame.
- Sits between a byte producer (processor / DMA) and the board TX pin.

Parameters:
- `CLKS_PER_BIT`, default 217, system clocks per serial bit (25 MHz / 115200 baud). Legal range ≥ 2.

Ports:
- `i_Clock`  input  1  system clock; all logic on rising edge.
- `i_Rst_L`  input  1  asynchronous active-low reset.
- `i_TX_DV`  input  1  data-valid strobe; a sample high while idle starts a frame. May be held high for several cycles.
- `i_TX_Byte`  input  8  byte to send; sampled only on the accepting cycle.
- `o_TX_Active`  output  1  high while a frame (start through stop bit) is on the line.
- `o_TX_Serial`  output  1  serial line; idles high.
- `o_TX_Done`  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- **Reset** (async assert, sync release):
  - state = IDLE, `o_TX_Serial` = 1, `o_TX_Active` = 0, `o_TX_Done` = 0.
  - Bit counter, clock counter and data register = 0.
  - Reset asserted mid-frame aborts the frame; the line goes high immediately with no done pulse.
- **States:** IDLE, START, DATA, STOP, CLEANUP. Clock counter width is `$clog2(CLKS_PER_BIT)`; bit index is 3 bits.
- **IDLE:**
  - `o_TX_Serial` = 1, `o_TX_Active` = 0, `o_TX_Done` = 0.
  - On a rising edge with `i_TX_DV` = 1: latch `i_TX_Byte`, go to START, assert `o_TX_Active`.
- **START:**
  - `o_TX_Serial` = 0 for exactly `CLKS_PER_BIT` cycles, starting the cycle after acceptance.
  - Then clear the clock counter, set bit index to 0, go to DATA.
- **DATA:**
  - `o_TX_Serial` = latched byte[bit index], each bit for `CLKS_PER_BIT` cycles.
  - Bit index increments 0..7; after bit 7 completes, go to STOP.
- **STOP:** `o_TX_Serial` = 1 for `CLKS_PER_BIT` cycles, then go to CLEANUP.
- **CLEANUP:**
  - Lasts exactly 1 cycle: `o_TX_Done` = 1, `o_TX_Active` = 0, `o_TX_Serial` = 1.
  - Then go to IDLE, with `o_TX_Done` back to 0.
- **Timing:**
  - Frame length on the wire is 10 × `CLKS_PER_BIT` cycles.
  - Acceptance to done pulse is 10 × `CLKS_PER_BIT` + 1 cycles.
  - Earliest next acceptance is 2 cycles after done rises (CLEANUP → IDLE → accept).
- **Handshake:**
  - `i_TX_DV` and `i_TX_Byte` are ignored in every state except IDLE.
  - A DV held high across CLEANUP → IDLE starts a new frame; the producer must drop DV to avoid a repeat.
  - Changes to `i_TX_Byte` after acceptance do not affect the frame in flight.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, CLEANUP);
  - default `CLKS_PER_BIT` constant;
  - data width constant 8.
- No sub-module required. If one is split out, name it `uart_bit_timer`: clock counter with a terminal-count flag at `CLKS_PER_BIT` − 1.

Test Plan:
1. **Reset values.** Hold `i_Rst_L` = 0 for 100 ns (40 ns clock). → Serial = 1, Active = 0, Done = 0 throughout reset and after release.
2. **Basic frame.** `CLKS_PER_BIT` = 217, byte 8'h37; DV high for 100 ns (3 edges).
   - Exactly one frame is sent; Active rises one cycle after the first DV edge.
   - Line shows 0 (start) then 1,1,1,0,1,1,0,0 then 1 (stop), each 8680 ns.
   - Done pulses for one cycle 86 840 ns after acceptance, and Active falls in that same cycle.
3. **Ignore DV while busy.** Pulse DV with 8'hA5 mid-frame of 8'h37. → The 8'h37 frame is unaffected and no second frame is sent.
4. **Back-to-back frames.** Send 8'h00, then 8'hFF with DV asserted the cycle after Done. → The second start bit begins 2 cycles after the first Done; both frames are bit-exact.
5. **Reset mid-frame.** Assert reset during data bit 3. → Serial goes to 1 and Active to 0 immediately; no Done pulse. A fresh 8'h55 frame after release is correct.
6. **Minimum divider.** `CLKS_PER_BIT` = 2, byte 8'h81. → Each bit lasts 2 cycles; frame is 20 cycles; Done arrives 21 cycles after acceptance.
